// File: rtl/mips_bus_lsu_if.sv
// Core-request / response and Avalon-MM master signals of the MIPS load/store unit.
// The LSU uses the master view; the core plus memory side uses the slave view.
interface mips_bus_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [31:0]       address;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  waitrequest, readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output address, read, write, writedata, byteenable
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output waitrequest, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mips_bus_lsu.sv
// Load/store unit: one core request becomes one Avalon transfer with byte lanes,
// load extension, misalignment rejection and a waitrequest timeout.
module mips_bus_lsu #(
    parameter int ADDR_W     = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic           clk,
    input  logic           reset,
    mips_bus_lsu_if.master bus
);

    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_done;
    logic             w_tmo;
    logic             w_illegal;
    logic [31:0]      w_addr32;

    logic             r_read;
    logic             r_write;
    logic [31:0]      r_address;
    logic [31:0]      r_writedata;
    logic [3:0]       r_byteenable;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [1:0]       r_ofs;
    logic [CNT_W-1:0] r_cnt;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] ofs);
        return (size == 2'b11) ||
               (size == 2'b01 && ofs[0]) ||
               (size == 2'b10 && ofs != 2'b00);
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'b00:   return 4'b0001 << ofs;
            2'b01:   return ofs[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Right-justify the addressed lanes, then truncate and extend to 32 bits.
    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] ofs, input logic [31:0] rdata);
        logic [31:0] s;
        s = rdata >> {ofs, 3'b000};
        case (size)
            2'b00:   return sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            2'b01:   return sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        w_addr32              = '0;
        w_addr32[ADDR_W-1:0]  = bus.req_addr;
        w_addr32[1:0]         = 2'b00;
        w_illegal             = is_illegal(bus.req_size, bus.req_addr[1:0]);
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_tmo  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_next = w_illegal ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                // A falling waitrequest on the limit edge is a completion, not a timeout.
                if (!bus.waitrequest) begin
                    w_next = ST_RESP;
                    w_done = 1'b1;
                end else if ((WAIT_LIMIT != 0) && (r_cnt == CNT_LIM)) begin
                    w_next = ST_RESP;
                    w_tmo  = 1'b1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_ofs        <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_address    <= w_addr32;
                            r_byteenable <= lane_enables(bus.req_size, bus.req_addr[1:0]);
                            r_writedata  <= lane_data(bus.req_size, bus.req_wdata);
                            r_read       <= !bus.req_write;
                            r_write      <= bus.req_write;
                            r_size       <= bus.req_size;
                            r_signed     <= bus.req_signed;
                            r_ofs        <= bus.req_addr[1:0];
                            r_cnt        <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    if (w_done) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_err   <= 1'b0;
                        r_rdata <= r_write ? 32'h0
                                           : extend_load(r_size, r_signed, r_ofs, bus.readdata);
                    end else if (w_tmo) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE) && !reset;
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.address    = r_address;
    assign bus.read       = r_read;
    assign bus.write      = r_write;
    assign bus.writedata  = r_writedata;
    assign bus.byteenable = r_byteenable;

endmodule
